// File: rtl/ifetch_unit.sv
// Instruction-fetch stage with the IF/ID pipeline register for miniRV-1.
// Holds the PC, addresses the IROM, and takes redirects from execute.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 14,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [31:0]       redirect_pc_i,
  output logic [ADDR_W-1:0] irom_addr_o,
  input  logic [31:0]       irom_inst_i,
  output logic [31:0]       pc_o,
  output logic [31:0]       pc_id_o,
  output logic [31:0]       pc4_id_o,
  output logic [31:0]       inst_id_o,
  output logic [24:0]       sext_inst_o,
  output logic              valid_id_o,
  output logic              misalign_o
);

  logic [31:0] pc_q,       pc_d;
  logic [31:0] pc_id_q,    pc_id_d;
  logic [31:0] pc4_id_q,   pc4_id_d;
  logic [31:0] inst_id_q,  inst_id_d;
  logic        valid_id_q, valid_id_d;
  logic        misalign_q, misalign_d;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    pc_d       = pc_q;
    pc_id_d    = pc_id_q;
    pc4_id_d   = pc4_id_q;
    inst_id_d  = inst_id_q;
    valid_id_d = valid_id_q;
    misalign_d = misalign_q;
    if (flush_i) begin
      // Flush overrides stall; the word fetched this cycle is dropped.
      pc_d       = {redirect_pc_i[31:2], 2'b00};
      inst_id_d  = NOP_INST;
      valid_id_d = 1'b0;
      if (redirect_pc_i[1:0] != 2'b00) begin
        misalign_d = 1'b1;
      end
    end else if (!stall_i) begin
      pc_d       = pc_plus4;
      pc_id_d    = pc_q;
      pc4_id_d   = pc_plus4;
      inst_id_d  = irom_inst_i;
      valid_id_d = 1'b1;
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      pc_q       <= RESET_PC;
      pc_id_q    <= '0;
      pc4_id_q   <= 32'd4;
      inst_id_q  <= NOP_INST;
      valid_id_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pc_id_q    <= pc_id_d;
      pc4_id_q   <= pc4_id_d;
      inst_id_q  <= inst_id_d;
      valid_id_q <= valid_id_d;
      misalign_q <= misalign_d;
    end
  end

  assign irom_addr_o = pc_q[ADDR_W+1:2];
  assign pc_o        = pc_q;
  assign pc_id_o     = pc_id_q;
  assign pc4_id_o    = pc4_id_q;
  assign inst_id_o   = inst_id_q;
  assign sext_inst_o = inst_id_q[31:7];
  assign valid_id_o  = valid_id_q;
  assign misalign_o  = misalign_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: IROM word = 0x100+index, except index 0x20
// which holds 0xFE01_0113 for the immediate-field check.
module tb_ifetch_unit;

  logic        cpu_clk;
  logic        cpu_rst;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] redirect_pc_i;
  logic [13:0] irom_addr_o;
  logic [31:0] irom_inst_i;
  logic [31:0] pc_o;
  logic [31:0] pc_id_o;
  logic [31:0] pc4_id_o;
  logic [31:0] inst_id_o;
  logic [24:0] sext_inst_o;
  logic        valid_id_o;
  logic        misalign_o;

  int unsigned passed;
  int unsigned total;

  ifetch_unit #(
    .RESET_PC(32'h0000_0000),
    .ADDR_W  (14),
    .NOP_INST(32'h0000_0013)
  ) dut (
    .cpu_clk      (cpu_clk),
    .cpu_rst      (cpu_rst),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .redirect_pc_i(redirect_pc_i),
    .irom_addr_o  (irom_addr_o),
    .irom_inst_i  (irom_inst_i),
    .pc_o         (pc_o),
    .pc_id_o      (pc_id_o),
    .pc4_id_o     (pc4_id_o),
    .inst_id_o    (inst_id_o),
    .sext_inst_o  (sext_inst_o),
    .valid_id_o   (valid_id_o),
    .misalign_o   (misalign_o)
  );

  assign irom_inst_i = (irom_addr_o == 14'h0020) ? 32'hFE01_0113
                                                 : 32'h0000_0100 + {18'd0, irom_addr_o};

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge cpu_clk);
    #1;
  endtask

  initial begin
    passed        = 0;
    total         = 0;
    cpu_rst       = 1'b1;
    stall_i       = 1'b0;
    flush_i       = 1'b0;
    redirect_pc_i = '0;
    step();
    step();
    check("rst_pc",       pc_o,        32'h0);
    check("rst_pc_id",    pc_id_o,     32'h0);
    check("rst_pc4_id",   pc4_id_o,    32'h4);
    check("rst_inst",     inst_id_o,   32'h13);
    check("rst_valid",    valid_id_o,  32'h0);
    check("rst_misalign", misalign_o,  32'h0);
    check("rst_addr",     irom_addr_o, 32'h0);

    cpu_rst = 1'b0;
    step();
    check("e1_pc",     pc_o,       32'h4);
    check("e1_inst",   inst_id_o,  32'h100);
    check("e1_pc_id",  pc_id_o,    32'h0);
    check("e1_pc4_id", pc4_id_o,   32'h4);
    check("e1_valid",  valid_id_o, 32'h1);
    check("e1_addr",   irom_addr_o, 32'h1);
    step();
    check("e2_pc",    pc_o,      32'h8);
    check("e2_inst",  inst_id_o, 32'h101);
    check("e2_pc_id", pc_id_o,   32'h4);

    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc",    pc_o,       32'h8);
      check("stall_inst",  inst_id_o,  32'h101);
      check("stall_valid", valid_id_o, 32'h1);
    end
    stall_i = 1'b0;
    step();
    check("post_stall_inst",  inst_id_o, 32'h102);
    check("post_stall_pc_id", pc_id_o,   32'h8);
    check("post_stall_pc",    pc_o,      32'hC);

    flush_i       = 1'b1;
    stall_i       = 1'b1;
    redirect_pc_i = 32'h40;
    step();
    check("flush_pc",     pc_o,       32'h40);
    check("flush_valid",  valid_id_o, 32'h0);
    check("flush_inst",   inst_id_o,  32'h13);
    check("flush_pc_id",  pc_id_o,    32'h8);
    check("flush_pc4_id", pc4_id_o,   32'hC);
    check("flush_sext",   sext_inst_o, 32'h0);
    flush_i = 1'b0;
    stall_i = 1'b0;
    step();
    check("tgt_inst",   inst_id_o,  32'h110);
    check("tgt_pc_id",  pc_id_o,    32'h40);
    check("tgt_pc4_id", pc4_id_o,   32'h44);
    check("tgt_valid",  valid_id_o, 32'h1);
    check("tgt_pc",     pc_o,       32'h44);
    check("no_misalign", misalign_o, 32'h0);

    flush_i       = 1'b1;
    redirect_pc_i = 32'h42;
    step();
    check("mis_pc",  pc_o,       32'h40);
    check("mis_set", misalign_o, 32'h1);
    flush_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("mis_sticky", misalign_o, 32'h1);
    end
    check("mis_run_pc", pc_o, 32'h68);

    // Reset together with a redirect: reset must win.
    cpu_rst       = 1'b1;
    flush_i       = 1'b1;
    redirect_pc_i = 32'h80;
    step();
    check("rst2_misalign", misalign_o, 32'h0);
    check("rst2_pc",       pc_o,       32'h0);
    check("rst2_valid",    valid_id_o, 32'h0);
    check("rst2_inst",     inst_id_o,  32'h13);
    cpu_rst = 1'b0;

    redirect_pc_i = 32'hFFFF_FFFC;
    step();
    check("wrap_pc0",   pc_o,        32'hFFFF_FFFC);
    check("wrap_addr0", irom_addr_o, 32'h3FFF);
    flush_i = 1'b0;
    step();
    check("wrap_pc",     pc_o,        32'h0);
    check("wrap_pc4_id", pc4_id_o,    32'h0);
    check("wrap_pc_id",  pc_id_o,     32'hFFFF_FFFC);
    check("wrap_inst",   inst_id_o,   32'h40FF);
    check("wrap_addr1",  irom_addr_o, 32'h0);

    flush_i       = 1'b1;
    redirect_pc_i = 32'h80;
    step();
    check("sext_flush_pc", pc_o, 32'h80);
    flush_i = 1'b0;
    step();
    check("sext_inst",  inst_id_o,   32'hFE01_0113);
    check("sext_field", sext_inst_o, 32'h1FC_0202);
    check("sext_pc_id", pc_id_o,     32'h80);
    check("sext_valid", valid_id_o,  32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
